// File: rtl/apb_command_bridge_if.sv
// Command/response handshake and APB master bus for apb_command_bridge.
// The slave modport is the bridge's view; master is the environment (command source, response sink, APB slave).
interface apb_command_bridge_if #(
  parameter int ADDRESS_WIDTH = 7,
  parameter int BUS_WIDTH     = 32
);
  logic                     i_cmd_valid;
  logic                     o_cmd_ready;
  logic                     i_cmd_write;
  logic [ADDRESS_WIDTH-1:0] i_cmd_address;
  logic [BUS_WIDTH-1:0]     i_cmd_write_data;
  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe;
  logic                     o_rsp_valid;
  logic                     i_rsp_ready;
  logic [1:0]               o_rsp_status;
  logic [BUS_WIDTH-1:0]     o_rsp_read_data;
  logic                     o_psel;
  logic                     o_penable;
  logic                     o_pwrite;
  logic [ADDRESS_WIDTH-1:0] o_paddr;
  logic [BUS_WIDTH-1:0]     o_pwdata;
  logic [BUS_WIDTH/8-1:0]   o_pstrb;
  logic [2:0]               o_pprot;
  logic                     i_pready;
  logic                     i_pslverr;
  logic [BUS_WIDTH-1:0]     i_prdata;

  modport slave (
    input  i_cmd_valid, i_cmd_write, i_cmd_address, i_cmd_write_data, i_cmd_strobe,
    input  i_rsp_ready, i_pready, i_pslverr, i_prdata,
    output o_cmd_ready, o_rsp_valid, o_rsp_status, o_rsp_read_data,
    output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_pprot
  );

  modport master (
    output i_cmd_valid, i_cmd_write, i_cmd_address, i_cmd_write_data, i_cmd_strobe,
    output i_rsp_ready, i_pready, i_pslverr, i_prdata,
    input  o_cmd_ready, o_rsp_valid, o_rsp_status, o_rsp_read_data,
    input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_pprot
  );
endinterface

// File: rtl/apb_command_bridge.sv
// Single-outstanding command-to-APB bridge with ACCESS-phase timeout.
// state    | meaning
// IDLE     | ready for a command
// SETUP    | psel=1, penable=0 for one cycle
// ACCESS   | psel=1, penable=1 until pready or timeout
// RESPONSE | rsp_valid held until rsp_ready
module apb_command_bridge #(
  parameter int ADDRESS_WIDTH  = 7,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  apb_command_bridge_if.slave bus
);
  localparam int SW = BUS_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPONSE} state_t;

  state_t                   r_state;
  logic                     r_psel;
  logic                     r_penable;
  logic                     r_pwrite;
  logic [ADDRESS_WIDTH-1:0] r_paddr;
  logic [BUS_WIDTH-1:0]     r_pwdata;
  logic [SW-1:0]            r_pstrb;
  logic                     r_rsp_valid;
  logic [1:0]               r_rsp_status;
  logic [BUS_WIDTH-1:0]     r_rsp_data;
  logic [CW-1:0]            r_cnt;
  logic                     w_timeout;

  assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_pstrb      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= 2'b00;
      r_rsp_data   <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_cmd_valid) begin
            r_pwrite <= bus.i_cmd_write;
            r_paddr  <= bus.i_cmd_address;
            r_pwdata <= bus.i_cmd_write_data;
            r_pstrb  <= bus.i_cmd_write ? bus.i_cmd_strobe : '0;
            r_psel   <= 1'b1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // pready wins over a timeout landing on the same cycle
          if (bus.i_pready) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= bus.i_pslverr ? 2'b01 : 2'b00;
            r_rsp_data   <= (!r_pwrite && !bus.i_pslverr) ? bus.i_prdata : '0;
            r_state      <= RESPONSE;
          end else if (w_timeout) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= 2'b10;
            r_rsp_data   <= '0;
            r_state      <= RESPONSE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESPONSE: begin
          if (bus.i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_cmd_ready     = (r_state == IDLE);
  assign bus.o_psel          = r_psel;
  assign bus.o_penable       = r_penable;
  assign bus.o_pwrite        = r_pwrite;
  assign bus.o_paddr         = r_paddr;
  assign bus.o_pwdata        = r_pwdata;
  assign bus.o_pstrb         = r_pstrb;
  assign bus.o_pprot         = 3'b000;
  assign bus.o_rsp_valid     = r_rsp_valid;
  assign bus.o_rsp_status    = r_rsp_status;
  assign bus.o_rsp_read_data = r_rsp_data;
endmodule
